muldiv_unit: RTL and testbench

Iterative, parametrised multiply/divide unit with HI/LO result registers for the pipelined MIPS core. It sits beside the ALU in the EX stage and executes MULT/MULTU/DIV/DIVU over WIDTH+1 cycles. While it runs it raises `busy`, which the hazard unit ORs into `Stall`. It also services MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO forwarding.

---
 rtl/muldiv_unit.sv | 192 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division; WIDTH+1 cycles per op.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // state   | meaning
  // S_IDLE  | waiting for start; MTHI/MTLO writes accepted here
  // S_RUN   | one shift-add / shift-subtract iteration per edge
  // S_FIX   | sign fixup, HI/LO write, done pulse
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH-1:0]   mag_a_q, mag_a_d;
  logic [WIDTH-1:0]   mag_b_q, mag_b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a_in, mag_b_in;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, raw_a;

  // op[0]==0 selects the signed variants (MULT, DIV)
  always_comb begin
    a_neg    = ~op[0] & a[WIDTH-1];
    b_neg    = ~op[0] & b[WIDTH-1];
    mag_a_in = a_neg ? (~a + 1'b1) : a;
    mag_b_in = b_neg ? (~b + 1'b1) : b;
  end

  // One multiply step: conditionally add multiplicand into the upper half, shift right
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  end

  // One restoring divide step: remainder in the upper half, quotient shifts into the lower half
  always_comb begin
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    rem_ge   = (rem_sh >= {1'b0, mag_b_q});
    rem_diff = rem_sh[WIDTH-1:0] - mag_b_q;
    if (rem_ge) begin
      div_next = {rem_diff, acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
    quo_fix  = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
    // dividend sign flag lets us rebuild the raw operand for the divide-by-zero result
    raw_a    = neg_rem_q ? (~mag_a_q + 1'b1) : mag_a_q;
  end

  always_comb begin
    state_d   = state_q;
    is_div_d  = is_div_q;
    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          state_d   = S_RUN;
          is_div_d  = op[1];
          mag_a_d   = mag_a_in;
          mag_b_d   = mag_b_in;
          neg_d     = a_neg ^ b_neg;
          neg_rem_d = op[1] & a_neg;
          cnt_d     = '0;
          acc_d     = op[1] ? {{WIDTH{1'b0}}, mag_a_in} : {{WIDTH{1'b0}}, mag_b_in};
        end else if (!start) begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            hi_d  = prod_fix[2*WIDTH-1:WIDTH];
            lo_d  = prod_fix[WIDTH-1:0];
            dbz_d = 1'b0;
          end else if (mag_b_q == '0) begin
            hi_d  = raw_a;
            lo_d  = '1;
            dbz_d = 1'b1;
          end else begin
            hi_d  = rem_fix;
            lo_d  = quo_fix;
            dbz_d = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      is_div_q  <= 1'b0;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_div_q  <= is_div_d;
      mag_a_q   <= mag_a_d;
      mag_b_q   <= mag_b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table of ops plus flush/reset/back-to-back/MTHI sequences.
module tb_muldiv_unit;
  localparam int W = 32;
  localparam int LAT = W + 1;

  logic          clk = 1'b0;
  logic          reset, start, flush, hi_we, lo_we;
  logic [1:0]    op;
  logic [W-1:0]  a, b, wdata;
  logic          busy, done, div_by_zero;
  logic [W-1:0]  hi, lo;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic        edbz;
  } vec_t;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Called right after the start edge; returns cycles until done (0 on timeout)
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    for (int n = 1; n <= LAT + 20; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic count_done(input int cycles, output int seen);
    seen = 0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
  endtask

  int lat, bc, seen;

  initial begin
    vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[4]  = '{OP_DIVU,  32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1};
    vecs[5]  = '{OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
    vecs[6]  = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
    vecs[7]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[8]  = '{OP_DIVU,  32'd9,        32'd4,        32'h00000001, 32'h00000002, 1'b0};
    vecs[9]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[10] = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vecs[11] = '{OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0};

    reset = 1'b1; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    #1;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_dbz", {63'd0, div_by_zero}, 64'd0);
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(lat, bc);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(LAT));
      check($sformatf("v%0d_busy_cycles", i), 64'(bc), 64'(LAT));
      check($sformatf("v%0d_busy_at_done", i), {63'd0, busy}, 64'd0);
      check($sformatf("v%0d_hi", i), {32'd0, hi}, {32'd0, vecs[i].ehi});
      check($sformatf("v%0d_lo", i), {32'd0, lo}, {32'd0, vecs[i].elo});
      check($sformatf("v%0d_dbz", i), {63'd0, div_by_zero}, {63'd0, vecs[i].edbz});
      @(posedge clk); #1;
      check($sformatf("v%0d_done_pulse", i), {63'd0, done}, 64'd0);
      check($sformatf("v%0d_dbz_hold", i), {63'd0, div_by_zero}, {63'd0, vecs[i].edbz});
    end

    // Back-to-back: second start issued in the done cycle of the first
    @(negedge clk);
    launch(OP_MULTU, 32'd3, 32'd5);
    wait_done(lat, bc);
    check("b2b_first_lat", 64'(lat), 64'(LAT));
    check("b2b_first_lo", {32'd0, lo}, 64'd15);
    launch(OP_DIVU, 32'd9, 32'd4);
    wait_done(lat, bc);
    check("b2b_second_lat", 64'(lat), 64'(LAT));
    check("b2b_second_lo", {32'd0, lo}, 64'd2);
    check("b2b_second_hi", {32'd0, hi}, 64'd1);

    // MTHI while busy is ignored
    @(negedge clk);
    launch(OP_MULTU, 32'd3, 32'd5);
    repeat (3) @(posedge clk);
    #1; hi_we = 1'b1; wdata = 32'hDEADBEEF;
    @(posedge clk); #1; hi_we = 1'b0;
    check("hi_we_busy", {32'd0, hi}, 64'd1);
    wait_done(lat, bc);
    check("hi_we_busy_result_hi", {32'd0, hi}, 64'd0);
    check("hi_we_busy_result_lo", {32'd0, lo}, 64'd15);

    // MTHI / MTLO in IDLE
    @(negedge clk); hi_we = 1'b1; wdata = 32'h00001234;
    @(posedge clk); #1; hi_we = 1'b0;
    check("mthi_idle", {32'd0, hi}, 64'h1234);
    @(negedge clk); lo_we = 1'b1; wdata = 32'h00005678;
    @(posedge clk); #1; lo_we = 1'b0;
    check("mtlo_idle", {32'd0, lo}, 64'h5678);
    check("mtlo_hi_kept", {32'd0, hi}, 64'h1234);

    // Flush 10 cycles after start
    @(negedge clk);
    launch(OP_DIVU, 32'd100, 32'd3);
    repeat (9) @(posedge clk);
    #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("flush_busy", {63'd0, busy}, 64'd0);
    count_done(LAT + 10, seen);
    check("flush_no_done", 64'(seen), 64'd0);
    check("flush_hi_kept", {32'd0, hi}, 64'h1234);
    check("flush_lo_kept", {32'd0, lo}, 64'h5678);

    // Flush in the same cycle as start suppresses it
    @(negedge clk); flush = 1'b1;
    launch(OP_MULTU, 32'd2, 32'd2);
    flush = 1'b0;
    check("flush_start_busy", {63'd0, busy}, 64'd0);

    // Reset pulsed mid-RUN clears everything immediately
    @(negedge clk);
    launch(OP_DIVU, 32'd100, 32'd0);
    repeat (5) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    #1;
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    check("rst_mid_hi", {32'd0, hi}, 64'd0);
    check("rst_mid_lo", {32'd0, lo}, 64'd0);
    check("rst_mid_done", {63'd0, done}, 64'd0);
    @(negedge clk); reset = 1'b0;
    count_done(LAT + 10, seen);
    check("rst_mid_no_done", 64'(seen), 64'd0);

    // Unit still operational after the reset
    @(negedge clk);
    launch(OP_MULT, 32'hFFFFFFFD, 32'd7);
    wait_done(lat, bc);
    check("post_rst_lat", 64'(lat), 64'(LAT));
    check("post_rst_hi", {32'd0, hi}, 64'hFFFFFFFF);
    check("post_rst_lo", {32'd0, lo}, 64'hFFFFFFEB);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
